// File: rtl/mips_encoder.sv
// MIPS instruction encoder: packs R/I/J field sets into 32-bit words and queues
// them, with their load addresses and per-word field-error flags, in a small FIFO.
module mips_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  OpCode,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] immediate,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic        FieldErr,
  output logic [7:0]  ErrCount,
  output logic [15:0] WordCount
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   addr_mem  [DEPTH];
  logic          err_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [15:0]   word_cnt_q, word_cnt_d;

  logic          is_r, is_j;
  logic [31:0]   enc_instr;
  logic          enc_err;
  logic          accept, pop;

  assign is_r = (OpCode == 6'd0);
  assign is_j = (OpCode == 6'd2) || (OpCode == 6'd3) || (OpCode == 6'd26);

  // Format-specific packing; unused fields only feed the error flag
  always_comb begin
    enc_instr = '0;
    enc_err   = 1'b0;
    if (is_r) begin
      enc_instr = {OpCode, Rs, Rt, Rd, shamt, funct};
      enc_err   = (immediate != 16'd0) || (target != 26'd0);
    end else if (is_j) begin
      enc_instr = {OpCode, target};
      enc_err   = (Rs != 5'd0) || (Rt != 5'd0) || (Rd != 5'd0) ||
                  (shamt != 5'd0) || (funct != 6'd0) || (immediate != 16'd0);
    end else begin
      enc_instr = {OpCode, Rs, Rt, immediate};
      enc_err   = (Rd != 5'd0) || (shamt != 5'd0) || (funct != 6'd0) ||
                  (target != 26'd0);
    end
  end

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready && !reset;
  assign pop       = out_valid && out_ready && !reset;

  // Head is read straight from storage; zeroed while empty so reset reads 0
  assign Instruction = out_valid ? instr_mem[rd_ptr_q] : 32'd0;
  assign Address     = out_valid ? addr_mem[rd_ptr_q]  : 32'd0;
  assign FieldErr    = out_valid ? err_mem[rd_ptr_q]   : 1'b0;
  assign ErrCount    = err_cnt_q;
  assign WordCount   = word_cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_d     = addr_q;
    err_cnt_d  = err_cnt_q;
    word_cnt_d = word_cnt_q;
    if (accept) begin
      wr_ptr_d   = wr_ptr_q + PW'(1);
      addr_d     = addr_q + 32'd4;
      word_cnt_d = word_cnt_q + 16'd1;
      if (enc_err && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({accept, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_q     <= BASE_ADDR;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      err_cnt_q  <= err_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Storage needs no reset: occupancy gates every read
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_mem[wr_ptr_q] <= enc_instr;
      addr_mem[wr_ptr_q]  <= addr_q;
      err_mem[wr_ptr_q]   <= enc_err;
    end
  end

endmodule

// File: tb/tb_mips_encoder.sv
// Directed bench for mips_encoder: table of single-word encodings plus
// backpressure, simultaneous push/pop, saturation and mid-stream reset sequences.
module tb_mips_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [5:0]  OpCode;
  logic [4:0]  Rs, Rt, Rd, shamt;
  logic [5:0]  funct;
  logic [15:0] immediate;
  logic [25:0] target;
  logic        out_valid, out_ready;
  logic [31:0] Instruction, Address;
  logic        FieldErr;
  logic [7:0]  ErrCount;
  logic [15:0] WordCount;

  int total  = 0;
  int passed = 0;

  mips_encoder #(.DEPTH(4), .BASE_ADDR(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .OpCode(OpCode), .Rs(Rs), .Rt(Rt), .Rd(Rd), .shamt(shamt), .funct(funct),
    .immediate(immediate), .target(target), .out_valid(out_valid),
    .out_ready(out_ready), .Instruction(Instruction), .Address(Address),
    .FieldErr(FieldErr), .ErrCount(ErrCount), .WordCount(WordCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic set_fields(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                            input logic [15:0] imm, input logic [25:0] tgt);
    OpCode = op; Rs = rs; Rt = rt; Rd = rd; shamt = sh; funct = fn;
    immediate = imm; target = tgt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_addr;
    int          n_err;
    int          got;
    logic        acc;
    logic [31:0] exp_q[$];

    // op rs rt rd sh fn imm tgt -> instruction, field error
    vecs[0] = '{6'd0,  5'd1,  5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0,       32'h0022_1820, 1'b0};
    vecs[1] = '{6'd8,  5'd1,  5'd2, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0,       32'h2022_0005, 1'b0};
    vecs[2] = '{6'd2,  5'd0,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h10,      32'h0800_0010, 1'b0};
    vecs[3] = '{6'd26, 5'd0,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0,       32'h6800_0000, 1'b0};
    vecs[4] = '{6'd0,  5'd1,  5'd2, 5'd3, 5'd0, 6'h20, 16'h1234, 26'h0,       32'h0022_1820, 1'b1};
    vecs[5] = '{6'd8,  5'd1,  5'd2, 5'd3, 5'd0, 6'h00, 16'h0005, 26'h0,       32'h2022_0005, 1'b1};
    vecs[6] = '{6'd3,  5'd1,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h0FFF_FFFF, 1'b1};
    vecs[7] = '{6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'hFFFC, 26'h0,       32'h8FA8_FFFC, 1'b0};
    vecs[8] = '{6'd0,  5'd1,  5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h55,      32'h0022_1820, 1'b1};
    vecs[9] = '{6'd0,  5'd0,  5'd2, 5'd3, 5'd4, 6'h00, 16'h0000, 26'h0,       32'h0002_1900, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset Instruction", Instruction, 32'd0);
    chk("reset Address", Address, 32'd0);
    chk("reset FieldErr", 32'(FieldErr), 32'd0);
    chk("reset counts", {8'd0, ErrCount, WordCount}, 32'd0);

    // Single-word table: accept, then check the head one cycle later while it pops
    exp_addr = 32'h0040_0000;
    n_err = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_fields(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                 vecs[i].fn, vecs[i].imm, vecs[i].tgt);
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (vecs[i].exp_err) n_err++;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d Instruction", i), Instruction, vecs[i].exp_instr);
      chk($sformatf("vec%0d Address", i), Address, exp_addr);
      chk($sformatf("vec%0d FieldErr", i), 32'(FieldErr), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d WordCount", i), 32'(WordCount), 32'(i + 1));
      chk($sformatf("vec%0d ErrCount", i), 32'(ErrCount), 32'(n_err));
      exp_addr += 32'd4;
    end

    // ErrCount saturation over 300 erroneous words
    do_reset();
    set_fields(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1234, 26'h0);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("sat ErrCount", 32'(ErrCount), 32'd255);
    chk("sat WordCount", 32'(WordCount), 32'd300);

    // Backpressure: four words fill the FIFO, fifth stalls until drain
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_fields(6'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'(k), 26'h0);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp in_ready full", 32'(in_ready), 32'd0);
    set_fields(6'd8, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'd4, 26'h0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("bp held in_ready", 32'(in_ready), 32'd0);
    chk("bp head stable", Instruction, 32'h2022_0000);
    chk("bp WordCount", 32'(WordCount), 32'd4);
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
      if (out_valid) begin
        chk($sformatf("bp drain%0d Instruction", got), Instruction, 32'h2022_0000 | 32'(got));
        chk($sformatf("bp drain%0d Address", got), Address, 32'h0040_0000 + 32'(4 * got));
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    chk("bp drained count", 32'(got), 32'd5);
    chk("bp final WordCount", 32'(WordCount), 32'd5);

    // Simultaneous accept and pop at occupancy 2
    do_reset();
    out_ready = 1'b0;
    exp_q = {};
    for (int k = 0; k < 2; k++) begin
      set_fields(6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'(16'hA0 + k));
      in_valid = 1'b1;
      exp_q.push_back(32'h0800_00A0 + 32'(k));
      @(posedge clk);
      @(negedge clk);
    end
    set_fields(6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'hA2);
    exp_q.push_back(32'h0800_00A2);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("simul head%0d", k), Instruction, exp_q.pop_front());
      chk($sformatf("simul addr%0d", k), Address, 32'h0040_0004 + 32'(4 * k));
      @(posedge clk);
      @(negedge clk);
    end
    chk("simul empty", 32'(out_valid), 32'd0);

    // Reset mid-stream with three words buffered; input held valid through reset
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_fields(6'd8, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'(k), 26'h0);
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk("mid-reset out_valid", 32'(out_valid), 32'd0);
    chk("mid-reset in_ready", 32'(in_ready), 32'd1);
    chk("mid-reset Instruction", Instruction, 32'd0);
    chk("mid-reset counts", {8'd0, ErrCount, WordCount}, 32'd0);
    set_fields(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post-reset Instruction", Instruction, 32'h0022_1820);
    chk("post-reset Address", Address, 32'h0040_0000);
    chk("post-reset WordCount", 32'(WordCount), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
